uart_tx_frame_fifo: RTL and testbench
=====================================

# uart_tx_frame_fifo

Parametrised, buffered UART transmitter for the AES link. It accepts words through a valid/ready handshake into an internal FIFO, then serialises them LSB-first with configurable data width, optional parity and one or two stop bits. Queued words go out back-to-back with no idle gap between frames. It sits between the AES output formatter and the board TX pin.

## Interface
- CLK_SPEED, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 625000: line rate in bit/s.
- COUNT_DIV, CLK_SPEED/BAUD_RATE: clock cycles per bit. Must be ≥ 2.
- DATA_BITS, 8: data bits per frame. Legal range 5..8.
- PARITY, PAR_NONE: one of PAR_NONE, PAR_ODD, PAR_EVEN (uart_pkg::parity_t).
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: TX FIFO entries. Power of two, ≥ 2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  DATA_BITS  word to transmit.
- valid_in  in  1  data_in is valid.
- ready  out  1  FIFO not full. A push happens when valid_in && ready at a rising edge.
- serial_out  out  1  TX line, idle high, registered.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of words held in the FIFO.

## Operation
- Reset values: serial_out=1, ready=1, busy=0, fifo_count=0, FSM=IDLE, baud counter=0. FIFO contents are discarded.
- Frame format: 1 start bit (0), then DATA_BITS data bits LSB-first, then the parity bit if PARITY≠PAR_NONE, then STOP_BITS stop bits (1).
- Parity:
  - PAR_EVEN: parity bit = XOR of the data bits.
  - PAR_ODD: parity bit = its inverse.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START when the FIFO is non-empty. This pops the head word into the shift register.
  - START → DATA at the end of the bit period.
  - DATA → PAR, or → STOP if no parity, after bit DATA_BITS-1.
  - PAR → STOP at the end of the bit period.
  - At the end of the last stop bit: → START, popping the next word, if the FIFO is non-empty; otherwise → IDLE.
- Bit index counter runs 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP. It clears on each state change.
- Baud counter runs 0..COUNT_DIV-1 in every non-IDLE state, wraps to 0, and is held at 0 in IDLE.
- FIFO:
  - fifo_count updates with push/pop in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - ready is derived from the registered count (count < FIFO_DEPTH). When full, a same-cycle pop does not enable a push.
  - A push while full is ignored and the FIFO contents are unchanged.

## Timing
- Handshake at edge E into an empty FIFO with FSM in IDLE:
  - Word is visible after E.
  - Pop and IDLE→START occur at E+1.
  - serial_out goes low after E+1.
- Every line bit lasts exactly COUNT_DIV cycles.
- Frame length = COUNT_DIV × (1 + DATA_BITS + (PARITY≠NONE) + STOP_BITS) cycles.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero gap.
- busy is high from the cycle after the pop until the cycle after the final stop bit of the last queued frame.
- rst mid-frame: on the next edge serial_out=1 and all state returns to reset values. Any partial frame is truncated; there is no completion.

## Structure
- uart_pkg holds:
  - parity_t enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - tx_state_t enum (IDLE, START, DATA, PAR, STOP).
  - Shared by the future parametrised receiver.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop, full/empty and count. The top level contains the FSM, baud counter and shift register.

## Test plan
- Use CLK_SPEED=16, BAUD_RATE=1 (COUNT_DIV=16) in all scenarios.
- 8N1, push 0xA5:
  - serial_out is low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16.
  - Start bit begins 2 cycles after the handshake.
  - busy=1 for exactly 160 cycles.
- 8E1 with 0x07: parity bit = 1. 8O1 with 0x07: parity bit = 0. 8E1 with 0x00: parity bit = 0. Frame is 176 cycles each.
- DATA_BITS=7, STOP_BITS=2, push 0x55:
  - Data bits are 1,0,1,0,1,0,1.
  - Stop high for 32 cycles.
  - Frame is 160 cycles.
- FIFO_DEPTH=4, valid_in held high for 6 cycles with 0x01..0x06:
  - 5 words accepted; ready drops after the 5th.
  - 0x06 is held until the first pop after frame 1.
  - serial_out carries 6 contiguous 8N1 frames, 960 cycles, with no idle cycle between them.
- Push 0x3C and 0xC3, assert rst for one cycle mid-data-bit of frame 1:
  - Next cycle: serial_out=1, busy=0, fifo_count=0, ready=1.
  - Line stays high afterwards; 0xC3 is never sent.
- FIFO full, then valid_in=1 with 0xFF:
  - Word is not accepted.
  - fifo_count stays at 4.
  - The transmitted sequence is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity mode and transmitter FSM state.
// The parametrised receiver will import these as well.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Data must be zero-extended so that unused upper bits do not disturb the XOR.
    function automatic logic parity_bit(input parity_t mode, input logic [7:0] data);
        logic even;
        even = ^data;
        return (mode == PAR_ODD) ? ~even : even;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_frame_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with baud counter, LSB-first data,
// optional parity and 1-2 stop bits; queued words are sent back-to-back.
//   state | meaning
//   IDLE  | line high, waiting for a queued word
//   START | start bit (0)
//   DATA  | data bits, LSB first
//   PAR   | parity bit
//   STOP  | stop bit(s) (1)
module uart_tx_frame_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_SPEED  = 100_000_000,
    parameter int      BAUD_RATE  = 625000,
    parameter int      COUNT_DIV  = CLK_SPEED / BAUD_RATE,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            data_in,
    input  logic                            valid_in,
    output logic                            ready,
    output logic                            serial_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int             BW        = (COUNT_DIV > 2) ? $clog2(COUNT_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(COUNT_DIV - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t             state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  serial_q, serial_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_BITS-1:0]  fifo_rdata;
    logic                  bit_end;

    // ready comes from the registered count, so a pop in the same cycle
    // never opens a slot for a push while full.
    assign ready = !fifo_full;
    assign busy  = (state_q != IDLE);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in && ready),
        .wdata (data_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        fifo_pop = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = START;
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY == PAR_NONE) ? STOP : PAR;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            state_d  = START;
                            fifo_pop = 1'b1;
                            data_d   = fifo_rdata;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            bit_d = '0;
        end
    end

    // The line is registered from the next state so it changes on the same
    // edge as the FSM, keeping every bit exactly COUNT_DIV cycles long.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = data_d[bit_d];
            PAR:     serial_d = parity_bit(PARITY, 8'(data_d));
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            serial_q <= serial_d;
        end
    end

    assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_frame_fifo.sv
// Directed bench for uart_tx_frame_fifo: four instances (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit.
// Inputs are driven on the falling edge; a recorder samples the selected instance 1 ns after each rising edge.
module tb_uart_tx_frame_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din [3];
    logic [6:0] din7;
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] ser_v;
    logic [3:0] busy_v;
    logic [2:0] cnt_v [4];

    uart_tx_frame_fifo #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PAR_NONE),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(valid_v[0]), .ready(ready_v[0]),
        .serial_out(ser_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));

    uart_tx_frame_fifo #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PAR_EVEN),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(valid_v[1]), .ready(ready_v[1]),
        .serial_out(ser_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));

    uart_tx_frame_fifo #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PAR_ODD),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid_in(valid_v[2]), .ready(ready_v[2]),
        .serial_out(ser_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));

    uart_tx_frame_fifo #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(PAR_NONE),
                         .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .data_in(din7), .valid_in(valid_v[3]), .ready(ready_v[3]),
        .serial_out(ser_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));

    int   checks   = 0;
    int   failures = 0;

    int   sel    = 0;
    bit   rec_en = 1'b0;
    int   rec_n  = 0;
    logic rec_ser  [0:1199];
    logic rec_busy [0:1199];

    always begin
        @(posedge clk);
        #1;
        if (rec_en && rec_n < 1200) begin
            rec_ser[rec_n]  = ser_v[sel];
            rec_busy[rec_n] = busy_v[sel];
            rec_n++;
        end
    end

    // Number of samples in one bit window that differ from the expected level.
    function automatic int win_err(input int base, input logic v);
        int e = 0;
        for (int i = 0; i < 16; i++) begin
            if (rec_ser[base+i] !== v) e++;
        end
        return e;
    endfunction

    function automatic int busy_ones(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (rec_busy[i] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic start_rec(input int id);
        sel    = id;
        rec_n  = 0;
        rec_en = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_v = '0;
        din[0]  = '0;
        din[1]  = '0;
        din[2]  = '0;
        din7    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ser_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || ready_v[i] !== 1'b1 || cnt_v[i] !== 3'd0) begin
                failures++;
                $display("FAIL reset_state inst%0d: ser=%b busy=%b ready=%b cnt=%0d want 1 0 1 0",
                         i, ser_v[i], busy_v[i], ready_v[i], cnt_v[i]);
            end
        end
    endtask

    task automatic test_8n1();
        logic exp_b [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   n;
        @(negedge clk);
        start_rec(0);
        din[0]     = 8'hA5;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (175) @(negedge clk);

        checks++;
        if (rec_ser[0] !== 1'b1) begin
            failures++;
            $display("FAIL 8n1_line_before_start: got %b want 1", rec_ser[0]);
        end
        checks++;
        n = win_err(1, 1'b0);
        if (n != 0) begin
            failures++;
            $display("FAIL 8n1_start_bit: %0d bad samples want 0", n);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            n = win_err(17 + 16*b, exp_b[b]);
            if (n != 0) begin
                failures++;
                $display("FAIL 8n1_data_bit%0d: %0d bad samples want 0 (level %b)", b, n, exp_b[b]);
            end
        end
        checks++;
        n = win_err(145, 1'b1);
        if (n != 0) begin
            failures++;
            $display("FAIL 8n1_stop_bit: %0d bad samples want 0", n);
        end
        checks++;
        n = busy_ones(0, 174);
        if (n != 160) begin
            failures++;
            $display("FAIL 8n1_busy_len: got %0d cycles want 160", n);
        end
        checks++;
        if (rec_busy[0] !== 1'b0 || rec_busy[1] !== 1'b1 || rec_busy[160] !== 1'b1 || rec_busy[161] !== 1'b0) begin
            failures++;
            $display("FAIL 8n1_busy_edges: got %b%b%b%b want 0110",
                     rec_busy[0], rec_busy[1], rec_busy[160], rec_busy[161]);
        end
        rec_en = 1'b0;
    endtask

    task automatic test_parity();
        int         inst_t [3] = '{1, 2, 1};
        logic [7:0] d_t    [3] = '{8'h07, 8'h07, 8'h00};
        logic       p_t    [3] = '{1'b1, 1'b0, 1'b0};
        int         n;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start_rec(inst_t[c]);
            din[inst_t[c]]     = d_t[c];
            valid_v[inst_t[c]] = 1'b1;
            @(negedge clk);
            valid_v[inst_t[c]] = 1'b0;
            repeat (190) @(negedge clk);

            checks++;
            n = win_err(1, 1'b0);
            for (int b = 0; b < 8; b++) n += win_err(17 + 16*b, d_t[c][b]);
            if (n != 0) begin
                failures++;
                $display("FAIL parity%0d_start_data: %0d bad samples want 0", c, n);
            end
            checks++;
            n = win_err(145, p_t[c]);
            if (n != 0) begin
                failures++;
                $display("FAIL parity%0d_parity_bit: %0d bad samples want 0 (level %b)", c, n, p_t[c]);
            end
            checks++;
            n = win_err(161, 1'b1);
            if (n != 0) begin
                failures++;
                $display("FAIL parity%0d_stop_bit: %0d bad samples want 0", c, n);
            end
            checks++;
            n = busy_ones(0, 190);
            if (n != 176) begin
                failures++;
                $display("FAIL parity%0d_frame_len: got %0d cycles want 176", c, n);
            end
            rec_en = 1'b0;
        end
    endtask

    task automatic test_7n2();
        logic exp_b [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   n;
        @(negedge clk);
        start_rec(3);
        din7       = 7'h55;
        valid_v[3] = 1'b1;
        @(negedge clk);
        valid_v[3] = 1'b0;
        repeat (175) @(negedge clk);

        checks++;
        n = win_err(1, 1'b0);
        if (n != 0) begin
            failures++;
            $display("FAIL 7n2_start_bit: %0d bad samples want 0", n);
        end
        for (int b = 0; b < 7; b++) begin
            checks++;
            n = win_err(17 + 16*b, exp_b[b]);
            if (n != 0) begin
                failures++;
                $display("FAIL 7n2_data_bit%0d: %0d bad samples want 0", b, n);
            end
        end
        checks++;
        n = win_err(129, 1'b1) + win_err(145, 1'b1);
        if (n != 0) begin
            failures++;
            $display("FAIL 7n2_two_stop_bits: %0d bad samples want 0", n);
        end
        checks++;
        n = busy_ones(0, 174);
        if (n != 160 || rec_busy[160] !== 1'b1 || rec_busy[161] !== 1'b0) begin
            failures++;
            $display("FAIL 7n2_frame_len: got %0d cycles want 160", n);
        end
        rec_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        int w;
        @(negedge clk);
        start_rec(0);
        valid_v[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            din[0] = 8'(k);
            checks++;
            if (ready_v[0] !== ((k <= 5) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL b2b_ready_word%0d: got %b want %b", k, ready_v[0], (k <= 5));
            end
            @(negedge clk);
        end
        checks++;
        if (cnt_v[0] !== 3'd4 || ready_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full: cnt=%0d ready=%b want 4 0", cnt_v[0], ready_v[0]);
        end
        w = 0;
        while (ready_v[0] !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 400) begin
            failures++;
            $display("FAIL b2b_ready_timeout: waited %0d cycles want <400", w);
        end
        checks++;
        if (rec_n != 162 || cnt_v[0] !== 3'd3) begin
            failures++;
            $display("FAIL b2b_first_pop: sample=%0d cnt=%0d want 162 3", rec_n, cnt_v[0]);
        end
        @(negedge clk);
        valid_v[0] = 1'b0;
        checks++;
        if (cnt_v[0] !== 3'd4) begin
            failures++;
            $display("FAIL b2b_word6_push: cnt=%0d want 4", cnt_v[0]);
        end
        w = 0;
        while (rec_n < 975 && w < 1200) begin
            @(negedge clk);
            w++;
        end
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d;
            d = 8'(f + 1);
            n = win_err(1 + 160*f, 1'b0) + win_err(145 + 160*f, 1'b1);
            for (int b = 0; b < 8; b++) n += win_err(17 + 160*f + 16*b, d[b]);
            checks++;
            if (n != 0) begin
                failures++;
                $display("FAIL b2b_frame%0d: %0d bad samples want 0", f, n);
            end
        end
        checks++;
        n = busy_ones(0, 974);
        if (n != 960 || rec_ser[961] !== 1'b1 || rec_busy[961] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_total_len: busy %0d cycles want 960", n);
        end
        rec_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        int bz;
        @(negedge clk);
        start_rec(0);
        din[0]     = 8'h3C;
        valid_v[0] = 1'b1;
        @(negedge clk);
        din[0] = 8'hC3;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (54) @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1 || cnt_v[0] !== 3'd1 || rec_ser[50] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: busy=%b cnt=%0d bit2=%b want 1 1 1", busy_v[0], cnt_v[0], rec_ser[50]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ser_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || cnt_v[0] !== 3'd0 || ready_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after: ser=%b busy=%b cnt=%0d ready=%b want 1 0 0 1",
                     ser_v[0], busy_v[0], cnt_v[0], ready_v[0]);
        end
        lows = 0;
        bz   = 0;
        repeat (400) begin
            @(negedge clk);
            if (ser_v[0] !== 1'b1) lows++;
            if (busy_v[0] !== 1'b0) bz++;
        end
        checks++;
        if (lows != 0 || bz != 0) begin
            failures++;
            $display("FAIL rstmid_idle: low=%0d busy=%0d cycles want 0 0", lows, bz);
        end
        rec_en = 1'b0;
    endtask

    task automatic test_full_drop();
        logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int n;
        int w;
        @(negedge clk);
        start_rec(0);
        valid_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din[0] = words[k];
            @(negedge clk);
        end
        din[0] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cnt_v[0] !== 3'd4 || ready_v[0] !== 1'b0) begin
                failures++;
                $display("FAIL full_drop_cycle%0d: cnt=%0d ready=%b want 4 0", k, cnt_v[0], ready_v[0]);
            end
        end
        valid_v[0] = 1'b0;
        w = 0;
        while (rec_n < 1001 && w < 1200) begin
            @(negedge clk);
            w++;
        end
        for (int f = 0; f < 5; f++) begin
            n = win_err(1 + 160*f, 1'b0) + win_err(145 + 160*f, 1'b1);
            for (int b = 0; b < 8; b++) n += win_err(17 + 160*f + 16*b, words[f][b]);
            checks++;
            if (n != 0) begin
                failures++;
                $display("FAIL full_drop_frame%0d: %0d bad samples want 0", f, n);
            end
        end
        n = 0;
        for (int i = 801; i < 1001; i++) begin
            if (rec_ser[i] !== 1'b1) n++;
        end
        checks++;
        if (n != 0 || rec_busy[801] !== 1'b0) begin
            failures++;
            $display("FAIL full_drop_no_extra_frame: %0d low samples want 0", n);
        end
        rec_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_reset_mid_frame();
        test_full_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
